hotbit: RTL and testbench



---
 rtl/hotbit_if.sv | 11 +
 rtl/hotbit.sv | 23 ++
 tb/tb_hotbit.sv | 83 ++++++++
 3 files changed

// File: rtl/hotbit_if.sv
// hotbit_if: write-select request and strobe bundle for the hotbit decoder
interface hotbit_if #(parameter int N = 32);
  localparam int W = $clog2(N);
  logic [W-1:0] reg_wr_cod;
  logic         wr_en;
  logic         Outn [N-1:0];
  logic         wr_any;
  logic         cod_err;
  modport master (output reg_wr_cod, wr_en, input Outn, wr_any, cod_err);
  modport slave (input reg_wr_cod, wr_en, output Outn, wr_any, cod_err);
endinterface

// File: rtl/hotbit.sv
// hotbit: registered one-hot write-strobe decoder for the register bank
module hotbit #(parameter int N = 32) (
  input logic clk,
  input logic rst_n,
  hotbit_if.slave bus
);
  localparam int W = $clog2(N);
  logic [N-1:0] out_d, out_q;
  logic any_d, any_q, err_d, err_q;
  always_comb begin
    for (int i = 0; i < N; i++) out_d[i] = bus.wr_en && (bus.reg_wr_cod == W'(i));
    any_d = |out_d;
    err_d = bus.wr_en && (32'(bus.reg_wr_cod) >= 32'(N));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {out_q, any_q, err_q} <= '0;
    else {out_q, any_q, err_q} <= {out_d, any_d, err_d};
  always_comb begin
    for (int i = 0; i < N; i++) bus.Outn[i] = out_q[i];
    bus.wr_any = any_q;
    bus.cod_err = err_q;
  end
endmodule

// File: tb/tb_hotbit.sv
// tb_hotbit: directed and random checks of hotbit at N=32 and N=20
module tb_hotbit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hotbit_if #(.N(32)) a();
  hotbit_if #(.N(20)) b();
  hotbit #(.N(32)) d32 (.clk(clk), .rst_n(rst_n), .bus(a));
  hotbit #(.N(20)) d20 (.clk(clk), .rst_n(rst_n), .bus(b));
  logic [31:0] oa;
  logic [19:0] ob;
  always_comb begin
    for (int i = 0; i < 32; i++) oa[i] = a.Outn[i];
    for (int i = 0; i < 20; i++) ob[i] = b.Outn[i];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Reference: a strobe exists only for an enabled, in-range index, outside reset
  task automatic model_chk(input string tag, input int n, input logic [63:0] obs,
                           input logic any, input logic err, input int c, input int e, input bit clr);
    bit hit;
    logic [63:0] vec;
    hit = !clr && e != 0 && c < n;
    vec = hit ? (64'd1 << c) : 64'd0;
    chk({tag, ".vec"}, obs, vec);
    chk({tag, ".pop"}, 64'($countones(obs)), hit ? 64'd1 : 64'd0);
    chk({tag, ".any"}, 64'(any), 64'(hit));
    chk({tag, ".err"}, 64'(err), 64'(!clr && e != 0 && c >= n));
  endtask
  task automatic cyc(input string tag, input int ca, input int ea, input int cb, input int eb);
    @(negedge clk);
    a.reg_wr_cod = 5'(ca);
    a.wr_en = ea[0];
    b.reg_wr_cod = 5'(cb);
    b.wr_en = eb[0];
    @(posedge clk);
    #1;
    model_chk({tag, ".n32"}, 32, 64'(oa), a.wr_any, a.cod_err, ca, ea, !rst_n);
    model_chk({tag, ".n20"}, 20, 64'(ob), b.wr_any, b.cod_err, cb, eb, !rst_n);
  endtask
  initial begin
    a.reg_wr_cod = 5'd6;
    a.wr_en = 1'b1;
    b.reg_wr_cod = 5'd3;
    b.wr_en = 1'b1;
    #12;
    model_chk("rst.n32", 32, 64'(oa), a.wr_any, a.cod_err, 6, 1, 1'b1);
    model_chk("rst.n20", 20, 64'(ob), b.wr_any, b.cod_err, 3, 1, 1'b1);
    cyc("rst_hold", 6, 1, 3, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("basic", 6, 1, 25, 1);
    cyc("gate0", 6, 0, 19, 0);
    cyc("gate1", 2, 0, 25, 0);
    cyc("retgt0", 2, 1, 0, 1);
    cyc("retgt1", 31, 1, 19, 1);
    for (int i = 0; i < 32; i++) cyc($sformatf("sweep%0d", i), i, 1, i, 1);
    cyc("oor0", 5, 0, 25, 1);
    cyc("oor1", 5, 0, 19, 1);
    cyc("arst_pre", 6, 1, 19, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_chk("arst.n32", 32, 64'(oa), a.wr_any, a.cod_err, 6, 1, 1'b1);
    model_chk("arst.n20", 20, 64'(ob), b.wr_any, b.cod_err, 19, 1, 1'b1);
    cyc("arst_hold", 6, 1, 19, 1);
    #1;
    rst_n = 1'b1;
    cyc("arst_rel", 6, 1, 19, 1);
    for (int i = 0; i < 300; i++)
      cyc("rand", int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
